// File: rtl/conv25d_window_engine.sv
// Streaming 2.5D convolution: per-channel window shift registers feeding
// pipelined multiply-adder trees. Optional macro: CONV25D_VALID_OUT_EN.
module conv25d_window_engine #(
    parameter int NUM_TREES    = 2,
    parameter int Z_DEPTH      = 2,
    parameter int P_SR_DEPTH   = 4,
    parameter int RAM_SR_DEPTH = 2,
    parameter int NUM_SR_ROWS  = 4,
    parameter int MA_TREE_SIZE = 16
) (
    input  logic                                           clock,
    input  logic                                           reset,
    input  logic [8*Z_DEPTH-1:0]                           pixel_vector_in,
    input  logic [8*NUM_TREES*MA_TREE_SIZE*Z_DEPTH-1:0]    kernel,
    output logic [32*NUM_TREES-1:0]                        pixel_vector_out
`ifdef CONV25D_VALID_OUT_EN
    ,
    output logic                                           pixel_valid_out
`endif
);

    localparam int S  = P_SR_DEPTH + RAM_SR_DEPTH;
    localparam int L  = (NUM_SR_ROWS - 1) * S + P_SR_DEPTH;
    localparam int N  = MA_TREE_SIZE * Z_DEPTH;
    localparam int D  = $clog2(N);
    localparam int NP = 1 << D;
    localparam int HN = 2 * NP - 1;

    // Index L-1 holds the newest pixel, index 0 the oldest.
    logic [7:0]  sr   [Z_DEPTH][L];
    logic [15:0] prod [NUM_TREES][NP];
    // Heap-ordered adder tree: node i sums children 2i+1 and 2i+2;
    // leaves NP-1 .. 2NP-2 are the product registers, node 0 the result.
    logic [31:0] heap [NUM_TREES][HN];

    // Window chain: every channel shifts one pixel per clock.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int z = 0; z < Z_DEPTH; z++)
                for (int i = 0; i < L; i++)
                    sr[z][i] <= '0;
        end else begin
            for (int z = 0; z < Z_DEPTH; z++) begin
                for (int i = 0; i < L - 1; i++)
                    sr[z][i] <= sr[z][i+1];
                sr[z][L-1] <= pixel_vector_in[8*z +: 8];
            end
        end
    end

    genvar t, n;
    generate
        for (t = 0; t < NUM_TREES; t++) begin : g_tree
            for (n = 0; n < NP; n++) begin : g_leaf
                if (n < N) begin : g_mul
                    localparam int ZI  = n / MA_TREE_SIZE;
                    localparam int KI  = n % MA_TREE_SIZE;
                    localparam int TAP = (KI / P_SR_DEPTH) * S
                                       + (KI % P_SR_DEPTH);
                    localparam int KB  = 8 * (MA_TREE_SIZE * (t * Z_DEPTH + ZI) + KI);
                    assign prod[t][n] = {8'b0, sr[ZI][TAP]}
                                      * {8'b0, kernel[KB +: 8]};
                end else begin : g_pad
                    assign prod[t][n] = '0;
                end
            end
            assign pixel_vector_out[32*t +: 32] = heap[t][0];
        end
    endgenerate

    // Product capture and one register per adder-tree level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int tt = 0; tt < NUM_TREES; tt++)
                for (int i = 0; i < HN; i++)
                    heap[tt][i] <= '0;
        end else begin
            for (int tt = 0; tt < NUM_TREES; tt++) begin
                for (int i = 0; i < NP - 1; i++)
                    heap[tt][i] <= heap[tt][2*i+1] + heap[tt][2*i+2];
                for (int j = 0; j < NP; j++)
                    heap[tt][NP-1+j] <= {16'b0, prod[tt][j]};
            end
        end
    end

`ifdef CONV25D_VALID_OUT_EN
    localparam int CW = $clog2(L + 1);
    localparam logic [CW-1:0] L_CNT = CW'(L);

    logic [CW-1:0] pix_cnt;
    logic [D:0]    valid_pipe;
    logic          win_full;

    assign win_full        = (pix_cnt == L_CNT);
    assign pixel_valid_out = valid_pipe[D];

    // Saturating fill counter, then a delay matching the datapath latency.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pix_cnt    <= '0;
            valid_pipe <= '0;
        end else begin
            if (!win_full)
                pix_cnt <= pix_cnt + 1'b1;
            valid_pipe <= {valid_pipe[D-1:0], win_full};
        end
    end
`endif

endmodule

// File: tb/tb_conv25d_window_engine.sv
// Directed bench for conv25d_window_engine: reset, ramp, tap order,
// full-scale arithmetic and mid-stream reset.
module tb_conv25d_window_engine;

    localparam int NT = 2;
    localparam int ZD = 2;
    localparam int MA = 16;
    localparam int KW = 8 * NT * MA * ZD;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [15:0]     pixel_vector_in = '0;
    logic [KW-1:0]   kernel = '0;
    logic [63:0]     pixel_vector_out;
`ifdef CONV25D_VALID_OUT_EN
    logic            pixel_valid_out;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    conv25d_window_engine dut (
        .clock            (clock),
        .reset            (reset),
        .pixel_vector_in  (pixel_vector_in),
        .kernel           (kernel),
        .pixel_vector_out (pixel_vector_out)
`ifdef CONV25D_VALID_OUT_EN
        ,
        .pixel_valid_out  (pixel_valid_out)
`endif
    );

    always #5 clock = ~clock;

    task automatic step(input logic [7:0] a, input logic [7:0] b);
        pixel_vector_in = {b, a};
        @(posedge clock);
        #1;
    endtask

    task automatic set_w(input int t, input int z, input int r,
                         input int c, input logic [7:0] w);
        kernel[8*(MA*(t*ZD+z) + r*4 + c) +: 8] = w;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        pixel_vector_in = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // Kernel 1: rows 0,1 = 2,2,1,1 (c0..c3), rows 2,3 = 1,1,2,2; z1 all 3.
    // Kernel 2: every row 3,3,2,2 (c0..c3); z1 all 4.
    task automatic load_ramp_kernel();
        kernel = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                set_w(0, 0, r, c, ((r < 2) == (c < 2)) ? 8'd2 : 8'd1);
                set_w(0, 1, r, c, 8'd3);
                set_w(1, 0, r, c, (c < 2) ? 8'd3 : 8'd2);
                set_w(1, 1, r, c, 8'd4);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            kernel = {16{$urandom()}};
            step(8'($urandom()), 8'($urandom()));
            n_cmp++;
            if (pixel_vector_out !== 64'd0) begin
                n_bad++;
                $display("FAIL reset_hold got=%h want=0", pixel_vector_out);
            end
        end
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(8'd0, 8'd0);
            if (i == 7) begin
                n_cmp++;
                if (pixel_vector_out !== 64'd0) begin
                    n_bad++;
                    $display("FAIL reset_release got=%h want=0",
                             pixel_vector_out);
                end
            end
        end
    endtask

    task automatic test_ramp();
        logic [31:0] e0, e1;
        load_ramp_kernel();
        do_reset();
        for (int p = 0; p <= 32; p++) begin
            step(8'(p), 8'(p));
            if (p == 26) begin
                n_cmp++;
                if (pixel_vector_out !== {32'd987, 32'd689}) begin
                    n_bad++;
                    $display("FAIL ramp_partial got=%h want=%h",
                             pixel_vector_out, {32'd987, 32'd689});
                end
            end
            if (p >= 27 && p <= 31) begin
                e0 = 32'(756 + 72 * (p - 27));
                e1 = 32'(1084 + 104 * (p - 27));
                n_cmp++;
                if (pixel_vector_out[31:0] !== e0) begin
                    n_bad++;
                    $display("FAIL ramp_tree0 p=%0d got=%0d want=%0d",
                             p, pixel_vector_out[31:0], e0);
                end
                n_cmp++;
                if (pixel_vector_out[63:32] !== e1) begin
                    n_bad++;
                    $display("FAIL ramp_tree1 p=%0d got=%0d want=%0d",
                             p, pixel_vector_out[63:32], e1);
                end
            end
`ifdef CONV25D_VALID_OUT_EN
            if (p == 26 || p == 27) begin
                n_cmp++;
                if (pixel_valid_out !== (p == 27)) begin
                    n_bad++;
                    $display("FAIL ramp_valid p=%0d got=%b want=%b",
                             p, pixel_valid_out, (p == 27));
                end
            end
`endif
        end
    endtask

    // Tree0 picks tap (0,0) of z0, tree1 picks tap (3,3) of z1.
    task automatic test_tap_order();
        logic [31:0] e;
        kernel = '0;
        set_w(0, 0, 0, 0, 8'd1);
        set_w(1, 1, 3, 3, 8'd1);
        do_reset();
        for (int p = 0; p <= 30; p++) begin
            step(8'(3 * p + 1), 8'(200 - p));
            if (p == 5 || (p >= 6 && p <= 8)) begin
                e = (p == 5) ? 32'd0 : 32'(200 - (p - 6));
                n_cmp++;
                if (pixel_vector_out[63:32] !== e) begin
                    n_bad++;
                    $display("FAIL tap33_delay p=%0d got=%0d want=%0d",
                             p, pixel_vector_out[63:32], e);
                end
            end
            if (p >= 26 && p <= 29) begin
                e = (p == 26) ? 32'd0 : 32'(3 * (p - 27) + 1);
                n_cmp++;
                if (pixel_vector_out[31:0] !== e) begin
                    n_bad++;
                    $display("FAIL tap00_delay p=%0d got=%0d want=%0d",
                             p, pixel_vector_out[31:0], e);
                end
            end
        end
    endtask

    task automatic test_overflow();
        kernel = '1;
        do_reset();
        for (int p = 0; p <= 28; p++) begin
            step(8'hff, 8'hff);
            if (p >= 27) begin
                n_cmp++;
                if (pixel_vector_out !== {32'd2080800, 32'd2080800}) begin
                    n_bad++;
                    $display("FAIL full_scale p=%0d got=%h want=%h", p,
                             pixel_vector_out, {32'd2080800, 32'd2080800});
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        load_ramp_kernel();
        do_reset();
        for (int p = 0; p <= 30; p++)
            step(8'(p), 8'(p));
        reset = 1'b0;
        #1;
        n_cmp++;
        if (pixel_vector_out !== 64'd0) begin
            n_bad++;
            $display("FAIL midreset_async got=%h want=0", pixel_vector_out);
        end
        step(8'd31, 8'd31);
        step(8'd32, 8'd32);
        n_cmp++;
        if (pixel_vector_out !== 64'd0) begin
            n_bad++;
            $display("FAIL midreset_hold got=%h want=0", pixel_vector_out);
        end
`ifdef CONV25D_VALID_OUT_EN
        n_cmp++;
        if (pixel_valid_out !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_valid got=%b want=0", pixel_valid_out);
        end
`endif
        reset = 1'b1;
        for (int p = 0; p <= 27; p++) begin
            step(8'(p), 8'(p));
            if (p == 26) begin
                n_cmp++;
                if (pixel_vector_out !== {32'd987, 32'd689}) begin
                    n_bad++;
                    $display("FAIL restart_partial got=%h want=%h",
                             pixel_vector_out, {32'd987, 32'd689});
                end
            end
            if (p == 27) begin
                n_cmp++;
                if (pixel_vector_out !== {32'd1084, 32'd756}) begin
                    n_bad++;
                    $display("FAIL restart_full got=%h want=%h",
                             pixel_vector_out, {32'd1084, 32'd756});
                end
            end
`ifdef CONV25D_VALID_OUT_EN
            if (p == 26 || p == 27) begin
                n_cmp++;
                if (pixel_valid_out !== (p == 27)) begin
                    n_bad++;
                    $display("FAIL restart_valid p=%0d got=%b want=%b",
                             p, pixel_valid_out, (p == 27));
                end
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_tap_order();
        test_overflow();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
